ex_wb_stage: RTL and testbench

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/ex_wb_stage.sv | 120 ++++++++++++
 tb/tb_ex_wb_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute stage with a 4-op ALU feeding the EX/WB pipeline register.
//
// Optional feature macro: EX_WB_FORWARD_EN
//   Defined   -> operands A/B are forwarded from the EX/WB register when the
//                previous instruction writes the register being read.
//   Undefined -> operands come straight from Data1_ID_EX / Data2_ID_EX.
//
// Ports
//   clk                 in   rising-edge clock
//   reset               in   synchronous active-low reset
//   Reg_Write_ID_EX     in   write enable of the instruction in EX
//   ALU_con_ID_EX       in   2-bit op: 00 ADD, 01 SUB, 10 AND, 11 OR
//   ALU_src_ID_EX       in   operand B select: 0 register, 1 immediate
//   Data1_ID_EX         in   operand A register value
//   Data2_ID_EX         in   operand B register value
//   Imm_ID_EX           in   sign-extended immediate
//   Read_Reg1_ID_EX     in   source address of operand A
//   Read_Reg2_ID_EX     in   source address of operand B
//   Write_Reg_ID_EX     in   destination address
//   Reg_Write_EX_WB     out  registered write enable
//   Result_EX_WB        out  registered ALU result
//   Write_Reg_EX_WB     out  registered destination address
//   Zero_EX_WB          out  zero flag of the last writing instruction
//   Carry_EX_WB         out  carry/borrow flag of the last writing instruction
//   Retired_Count       out  saturating count of retired writing instructions
module ex_wb_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Reg_Write_ID_EX,
    input  logic [1:0]        ALU_con_ID_EX,
    input  logic              ALU_src_ID_EX,
    input  logic [DATA_W-1:0] Data1_ID_EX,
    input  logic [DATA_W-1:0] Data2_ID_EX,
    input  logic [DATA_W-1:0] Imm_ID_EX,
    input  logic [ADDR_W-1:0] Read_Reg1_ID_EX,
    input  logic [ADDR_W-1:0] Read_Reg2_ID_EX,
    input  logic [ADDR_W-1:0] Write_Reg_ID_EX,
    output logic              Reg_Write_EX_WB,
    output logic [DATA_W-1:0] Result_EX_WB,
    output logic [ADDR_W-1:0] Write_Reg_EX_WB,
    output logic              Zero_EX_WB,
    output logic              Carry_EX_WB,
    output logic [15:0]       Retired_Count
);

    localparam int unsigned WIDE_W  = DATA_W + 1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b_reg;
    logic [DATA_W-1:0] op_b;
    logic [WIDE_W-1:0] alu_wide;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

`ifndef EX_WB_FORWARD_EN
    // Source addresses only matter when forwarding is built.
    logic unused_read_regs;
    assign unused_read_regs = ^{Read_Reg1_ID_EX, Read_Reg2_ID_EX};
`endif

    // Operand selection, with optional forwarding from the EX/WB register.
    always_comb begin
        op_a     = Data1_ID_EX;
        op_b_reg = Data2_ID_EX;
`ifdef EX_WB_FORWARD_EN
        // Reg_Write_EX_WB is cleared by reset, so nothing forwards right after it.
        if (Reg_Write_EX_WB && (Write_Reg_EX_WB == Read_Reg1_ID_EX)) begin
            op_a = Result_EX_WB;
        end
        if (Reg_Write_EX_WB && (Write_Reg_EX_WB == Read_Reg2_ID_EX)) begin
            op_b_reg = Result_EX_WB;
        end
`endif
        op_b = ALU_src_ID_EX ? Imm_ID_EX : op_b_reg;
    end

    // ALU evaluated one bit wider; the top bit is carry for ADD and borrow for SUB.
    always_comb begin
        alu_wide = '0;
        case (ALU_con_ID_EX)
            2'b00:   alu_wide = {1'b0, op_a} + {1'b0, op_b};
            2'b01:   alu_wide = {1'b0, op_a} - {1'b0, op_b};
            2'b10:   alu_wide = {1'b0, op_a & op_b};
            default: alu_wide = {1'b0, op_a | op_b};
        endcase
        alu_result = alu_wide[DATA_W-1:0];
        alu_carry  = alu_wide[DATA_W];
        alu_zero   = (alu_result == '0);
    end

    // EX/WB pipeline register, flags and retire counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Reg_Write_EX_WB <= 1'b0;
            Result_EX_WB    <= '0;
            Write_Reg_EX_WB <= '0;
            Zero_EX_WB      <= 1'b0;
            Carry_EX_WB     <= 1'b0;
            Retired_Count   <= 16'd0;
        end else begin
            Reg_Write_EX_WB <= Reg_Write_ID_EX;
            Result_EX_WB    <= alu_result;
            Write_Reg_EX_WB <= Write_Reg_ID_EX;
            // Flags track only instructions that actually write back.
            if (Reg_Write_ID_EX) begin
                Zero_EX_WB  <= alu_zero;
                Carry_EX_WB <= alu_carry;
                if (Retired_Count != CNT_MAX) begin
                    Retired_Count <= Retired_Count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: directed stimulus for ex_wb_stage, checked every cycle
// against a behavioural model, plus literal expectations at key points.
// Follows EX_WB_FORWARD_EN in the same way as the design.
module tb_ex_wb_stage;

    logic       clk;
    logic       reset;
    logic       rw;
    logic [1:0] op;
    logic       src;
    logic [7:0] d1, d2, imm;
    logic [2:0] rr1, rr2, wr;

    logic       o_rw;
    logic [7:0] o_res;
    logic [2:0] o_wr;
    logic       o_z, o_c;
    logic [15:0] o_cnt;

    int checks   = 0;
    int failures = 0;

    ex_wb_stage #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .Reg_Write_ID_EX (rw),
        .ALU_con_ID_EX   (op),
        .ALU_src_ID_EX   (src),
        .Data1_ID_EX     (d1),
        .Data2_ID_EX     (d2),
        .Imm_ID_EX       (imm),
        .Read_Reg1_ID_EX (rr1),
        .Read_Reg2_ID_EX (rr2),
        .Write_Reg_ID_EX (wr),
        .Reg_Write_EX_WB (o_rw),
        .Result_EX_WB    (o_res),
        .Write_Reg_EX_WB (o_wr),
        .Zero_EX_WB      (o_z),
        .Carry_EX_WB     (o_c),
        .Retired_Count   (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the architectural rules.
    bit m_valid = 0;
    int m_rw, m_res, m_wr, m_z, m_c, m_cnt;

    always @(posedge clk) begin
        int a, b, r, cy;
        if (!reset) begin
            m_valid <= 1;
            m_rw <= 0; m_res <= 0; m_wr <= 0; m_z <= 0; m_c <= 0; m_cnt <= 0;
        end else if (m_valid) begin
            a = int'(d1);
            b = int'(d2);
`ifdef EX_WB_FORWARD_EN
            if (m_rw == 1 && m_wr == int'(rr1)) a = m_res;
            if (m_rw == 1 && m_wr == int'(rr2)) b = m_res;
`endif
            if (src) b = int'(imm);
            case (op)
                2'd0: begin r = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
                2'd1: begin r = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
                2'd2: begin r = a & b; cy = 0; end
                default: begin r = a | b; cy = 0; end
            endcase
            m_rw  <= int'(rw);
            m_res <= r;
            m_wr  <= int'(wr);
            if (rw) begin
                m_z <= (r == 0) ? 1 : 0;
                m_c <= cy;
                if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_reg_write", 32'(o_rw),  32'(m_rw));
            chk("cyc_result",    32'(o_res), 32'(m_res));
            chk("cyc_write_reg", 32'(o_wr),  32'(m_wr));
            chk("cyc_zero",      32'(o_z),   32'(m_z));
            chk("cyc_carry",     32'(o_c),   32'(m_c));
            chk("cyc_count",     32'(o_cnt), 32'(m_cnt));
        end
    end

    // Present one instruction for one edge; return #1 after that edge.
    task automatic issue(input logic i_rw, input logic [1:0] i_op, input logic i_src,
                         input logic [7:0] i_d1, input logic [7:0] i_d2, input logic [7:0] i_imm,
                         input logic [2:0] i_rr1, input logic [2:0] i_rr2, input logic [2:0] i_wr,
                         input logic i_reset = 1'b1);
        @(negedge clk);
        reset = i_reset;
        rw = i_rw; op = i_op; src = i_src;
        d1 = i_d1; d2 = i_d2; imm = i_imm;
        rr1 = i_rr1; rr2 = i_rr2; wr = i_wr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset for two edges with a live writing instruction on the inputs.
        reset = 1'b0;
        rw = 1'b1; op = 2'b00; src = 1'b0;
        d1 = 8'h55; d2 = 8'hAA; imm = 8'h11;
        rr1 = 3'd1; rr2 = 3'd2; wr = 3'd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_reg_write", 32'(o_rw),  32'd0);
        chk("rst_result",    32'(o_res), 32'd0);
        chk("rst_write_reg", 32'(o_wr),  32'd0);
        chk("rst_flags",     32'({o_z, o_c}), 32'd0);
        chk("rst_count",     32'(o_cnt), 32'd0);

        // ADD F0 + imm 20 -> 10 with carry, into r3.
        issue(1, 2'b00, 1, 8'hF0, 8'h00, 8'h20, 3'd0, 3'd1, 3'd3);
        chk("add_imm_result", 32'(o_res), 32'h10);
        chk("add_imm_carry",  32'(o_c),   32'd1);
        chk("add_imm_zero",   32'(o_z),   32'd0);
        chk("add_imm_wr",     32'(o_wr),  32'd3);
        chk("add_imm_count",  32'(o_cnt), 32'd1);

        // SUB 5-5 -> zero; then a non-writing AND leaves flags alone.
        issue(1, 2'b01, 0, 8'h05, 8'h05, 8'h00, 3'd5, 3'd6, 3'd4);
        chk("sub_eq_result", 32'(o_res), 32'h00);
        chk("sub_eq_flags",  32'({o_z, o_c}), 32'b10);
        issue(0, 2'b10, 0, 8'hFF, 8'h0F, 8'h00, 3'd5, 3'd6, 3'd2);
        chk("and_nw_result", 32'(o_res), 32'h0F);
        chk("and_nw_rw",     32'(o_rw),  32'd0);
        chk("and_nw_flags",  32'({o_z, o_c}), 32'b10);
        chk("and_nw_count",  32'(o_cnt), 32'd2);

        // SUB with borrow and an OR.
        issue(1, 2'b01, 0, 8'h03, 8'h05, 8'h00, 3'd5, 3'd6, 3'd1);
        chk("sub_borrow", 32'({o_c, o_res}), 32'h1FE);
        issue(1, 2'b11, 0, 8'hA0, 8'h0A, 8'h00, 3'd5, 3'd6, 3'd6);
        chk("or_result", 32'({o_c, o_res}), 32'h0AA);

        // r1 := 3+4, then r2 := r1+r1 with stale register data of zero.
        issue(1, 2'b00, 0, 8'h03, 8'h04, 8'h00, 3'd5, 3'd5, 3'd1);
        issue(1, 2'b00, 0, 8'h00, 8'h00, 8'h00, 3'd1, 3'd1, 3'd2);
`ifdef EX_WB_FORWARD_EN
        chk("fwd_dep_add", 32'(o_res), 32'h0E);
`else
        chk("fwd_dep_add", 32'(o_res), 32'h00);
`endif

        // Back-to-back writes to r0, immediate B ignores operand-B forward.
        issue(1, 2'b00, 0, 8'h10, 8'h01, 8'h00, 3'd5, 3'd5, 3'd0);
        issue(1, 2'b00, 0, 8'h20, 8'h02, 8'h00, 3'd5, 3'd5, 3'd0);
        issue(1, 2'b00, 1, 8'h01, 8'h40, 8'h05, 3'd0, 3'd0, 3'd4);
`ifdef EX_WB_FORWARD_EN
        chk("fwd_r0_imm", 32'(o_res), 32'h27);
`else
        chk("fwd_r0_imm", 32'(o_res), 32'h06);
`endif

        // Reset between two dependent ADDs: no forward, count restarts.
        issue(1, 2'b00, 0, 8'h01, 8'h02, 8'h00, 3'd5, 3'd5, 3'd1);
        issue(1, 2'b00, 0, 8'h33, 8'h44, 8'h00, 3'd1, 3'd1, 3'd1, 1'b0);
        chk("mid_rst_count", 32'(o_cnt), 32'd0);
        issue(1, 2'b00, 0, 8'h10, 8'h01, 8'h00, 3'd1, 3'd1, 3'd2);
        chk("mid_rst_dep",   32'(o_res), 32'h11);
        chk("mid_rst_count1", 32'(o_cnt), 32'd1);

        // Drive the counter to saturation and past it.
        for (int i = 0; i < 65537; i++) begin
            issue(1, 2'b10, 0, 8'(i), 8'hFF, 8'h00, 3'd5, 3'd6, 3'(i));
        end
        chk("sat_count", 32'(o_cnt), 32'hFFFF);
        issue(1, 2'b00, 0, 8'h01, 8'h01, 8'h00, 3'd5, 3'd6, 3'd3);
        chk("sat_count_hold", 32'(o_cnt), 32'hFFFF);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
